counter_call_dispatcher: RTL
============================

Name: counter_call_dispatcher

Overview:
Calling side of the response system: issued tickets enter a waiting queue, and free service counters (A–E) request the next customer. The block arbitrates counter requests round-robin, pops the oldest waiting ticket and presents a call announcement (number and counter) to the display/voice unit over a valid/ready handshake. It sits between the ticket issuer (button/current_number) and the per-counter service displays.

Parameters:
NUM_COUNTERS, 5, number of service counters (ids 0..4 = A..E)
NUM_W, 6, ticket number width
DEPTH, 16, waiting-queue depth (power of two)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
ticket_valid  in  1  one-cycle pulse: new ticket issued
ticket_number  in  NUM_W  number of issued ticket
counter_req  in  NUM_COUNTERS  per-counter "ready for next customer" pulse
call_ready  in  1  display accepts announcement
call_valid  out  1  announcement pending
call_number  out  NUM_W  ticket being called
call_counter  out  3  counter id being called
service_numbers  out  NUM_COUNTERS*NUM_W  last number served per counter, counter 0 in LSBs
waiting_count  out  5  tickets in queue (0..DEPTH)
queue_empty  out  1  waiting_count==0
queue_full  out  1  waiting_count==DEPTH
overflow  out  1  sticky: ticket dropped while full

Behaviour:
- Reset (rst==0 at clk edge): queue emptied, pending requests cleared, RR pointer=0, FSM=IDLE, every output 0 except queue_empty=1. Reset mid-announce abandons the call; the popped ticket is lost.
- Queue: FIFO. Push on ticket_valid when not full. Push while full: ticket dropped, overflow set until reset. Push and pop in the same cycle are both allowed; count unchanged.
- Requests: counter_req bits OR into a pending register. A re-request from an already-pending counter is a no-op. A counter's pending bit clears only when its call is accepted.
- FSM:
  - IDLE -> ARB when any pending bit is set and the queue is not empty.
  - ARB (1 cycle): pick the first pending counter at or after the RR pointer, wrapping modulo NUM_COUNTERS. Pop the queue head into call_number, set call_counter, go to ANNOUNCE.
  - ANNOUNCE: call_valid=1. call_number and call_counter stay stable until call_valid && call_ready.
  - On accept: service_numbers[id]<=call_number, pending[id] cleared, RR pointer<=id+1 (wraps 4->0). Back to IDLE, or straight to ARB if work remains.
- Latency: with a request pending and the queue non-empty, call_valid rises 2 cycles after the enabling event (IDLE, ARB, then ANNOUNCE visible).
- Requests arriving during ANNOUNCE are latched and served afterwards. A ticket pushed into an empty queue while requests are pending triggers ARB on the next cycle.
- Ticket numbers are carried unchanged (issuer wraps at 2^NUM_W). No arithmetic is done on them.

Optional Feature:
Macro CALL_RECALL_EN.
- Defined: extra inputs recall_req (1) and recall_counter (3).
  - In IDLE, a recall_req for a counter with a nonzero service number re-announces that counter's number. No pop, no pending change, no RR change.
  - Recall has priority over new calls in the same cycle.
  - recall_req outside IDLE is ignored.
- Undefined: the ports and logic are absent; behaviour is as above.

Decomposition:
- Shared package response_pkg holds: NUM_W, NUM_COUNTERS, counter id constants CNT_A..CNT_E (0..4), and the FSM state enum (IDLE, ARB, ANNOUNCE).
- One natural sub-module: ticket_fifo (parameterised DEPTH/NUM_W, push/pop/count/full/empty).
- The round-robin picker stays inline.

Test Plan:
- Reset, push tickets 1,2,3, then pulse counter_req=5'b00001 with call_ready held 1 -> call_valid, number 1, counter 0 two cycles later. service_numbers[5:0]=1. waiting_count=2.
- counter_req=5'b10110 in the same cycle with tickets 4,5,6 queued, RR pointer=0 -> calls in order B:4, C:5, E:6. RR pointer ends at 0.
- Counter D requests with the queue empty, ticket 7 arrives 5 cycles later -> D:7 announced 2 cycles after the push.
- call_ready held 0 for 4 cycles during ANNOUNCE while a new ticket arrives -> call fields stable, no second call, waiting_count increments. Accept on cycle 5.
- Push 17 tickets with no requests -> queue_full=1 at 16, ticket 17 dropped, overflow=1. A subsequent pop starts with the first ticket.
- Assert rst=0 during ANNOUNCE -> next cycle call_valid=0, waiting_count=0, service_numbers=0. With CALL_RECALL_EN: after A serves 9, recall_req for A -> call A:9, waiting_count unchanged.

Source files
------------

// File: rtl/response_pkg.sv
// Shared constants, counter ids and dispatcher FSM states for the response system.
package response_pkg;
  localparam int NUM_COUNTERS = 5;
  localparam int NUM_W        = 6;
  localparam int DEPTH        = 16;

  localparam logic [2:0] CNT_A = 3'd0;
  localparam logic [2:0] CNT_B = 3'd1;
  localparam logic [2:0] CNT_C = 3'd2;
  localparam logic [2:0] CNT_D = 3'd3;
  localparam logic [2:0] CNT_E = 3'd4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARB      = 2'd1,
    ANNOUNCE = 2'd2
  } state_t;
endpackage

// File: rtl/ticket_fifo.sv
// Waiting-ticket FIFO: push is dropped when full, pop is ignored when empty.
// Head is visible combinationally; count/full/empty follow the registered occupancy.
module ticket_fifo #(
  parameter int DEPTH = 16,
  parameter int NUM_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [NUM_W-1:0]         push_data,
  input  logic                     pop,
  output logic [NUM_W-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [NUM_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/counter_call_dispatcher.sv
// Round-robin dispatch of queued tickets to requesting counters; call_valid rises 2 cycles after work appears
// and holds number/counter until call_ready. Define CALL_RECALL_EN to add re-announcement of a served number.
module counter_call_dispatcher #(
  parameter int NUM_COUNTERS = response_pkg::NUM_COUNTERS,
  parameter int NUM_W        = response_pkg::NUM_W,
  parameter int DEPTH        = response_pkg::DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ticket_valid,
  input  logic [NUM_W-1:0]              ticket_number,
  input  logic [NUM_COUNTERS-1:0]       counter_req,
  input  logic                          call_ready,
  output logic                          call_valid,
  output logic [NUM_W-1:0]              call_number,
  output logic [2:0]                    call_counter,
  output logic [NUM_COUNTERS*NUM_W-1:0] service_numbers,
  output logic [$clog2(DEPTH):0]        waiting_count,
  output logic                          queue_empty,
  output logic                          queue_full,
  output logic                          overflow
`ifdef CALL_RECALL_EN
  ,
  input  logic                          recall_req,
  input  logic [2:0]                    recall_counter
`endif
);
  import response_pkg::*;

  typedef struct packed {
    logic [NUM_W-1:0] number;
    logic [2:0]       counter;
  } call_t;

  state_t                  state;
  call_t                   call_q;
  logic [NUM_COUNTERS-1:0] pending;
  logic [NUM_COUNTERS-1:0] pending_next;
  logic [NUM_COUNTERS-1:0] clear_mask;
  logic [2:0]              rr_ptr;
  logic [2:0]              pick;
  logic [2:0]              idx;
  logic                    found;
  logic                    accept;
  logic                    fifo_pop;
  logic [NUM_W-1:0]        head;
  logic                    call_is_recall;

  assign call_number  = call_q.number;
  assign call_counter = call_q.counter;
  assign accept       = call_valid && call_ready;
  assign fifo_pop     = (state == ARB) && found;

  ticket_fifo #(.DEPTH(DEPTH), .NUM_W(NUM_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ticket_valid),
    .push_data (ticket_number),
    .pop       (fifo_pop),
    .pop_data  (head),
    .count     (waiting_count),
    .full      (queue_full),
    .empty     (queue_empty)
  );

  // Scan pending counters starting at the round-robin pointer, wrapping at the last counter.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = rr_ptr;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (!found && pending[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
      idx = (idx == 3'(NUM_COUNTERS-1)) ? 3'd0 : idx + 3'd1;
    end
  end

  always_comb begin
    clear_mask = '0;
    if (accept && !call_is_recall) begin
      for (int c = 0; c < NUM_COUNTERS; c++)
        if (call_q.counter == 3'(c)) clear_mask[c] = 1'b1;
    end
    pending_next = (pending | counter_req) & ~clear_mask;
  end

`ifdef CALL_RECALL_EN
  logic             recall_hit;
  logic [NUM_W-1:0] recall_number;

  // An out-of-range counter id reads as zero and so never triggers a recall.
  always_comb begin
    recall_number = '0;
    for (int c = 0; c < NUM_COUNTERS; c++)
      if (recall_counter == 3'(c)) recall_number = service_numbers[c*NUM_W +: NUM_W];
    recall_hit = recall_req && (recall_number != '0);
  end
`else
  assign call_is_recall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      pending         <= '0;
      rr_ptr          <= '0;
      call_valid      <= 1'b0;
      call_q          <= '0;
      service_numbers <= '0;
      overflow        <= 1'b0;
`ifdef CALL_RECALL_EN
      call_is_recall  <= 1'b0;
`endif
    end else begin
      pending <= pending_next;
      if (ticket_valid && queue_full) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (|pending && !queue_empty) state <= ARB;
`ifdef CALL_RECALL_EN
          if (recall_hit) begin
            call_q         <= '{number: recall_number, counter: recall_counter};
            call_valid     <= 1'b1;
            call_is_recall <= 1'b1;
            state          <= ANNOUNCE;
          end
`endif
        end
        ARB: begin
          if (found) begin
            call_q     <= '{number: head, counter: pick};
            call_valid <= 1'b1;
            state      <= ANNOUNCE;
          end else begin
            state <= IDLE;
          end
        end
        ANNOUNCE: begin
          if (accept) begin
            call_valid <= 1'b0;
`ifdef CALL_RECALL_EN
            call_is_recall <= 1'b0;
`endif
            if (!call_is_recall) begin
              for (int c = 0; c < NUM_COUNTERS; c++)
                if (call_q.counter == 3'(c)) service_numbers[c*NUM_W +: NUM_W] <= call_q.number;
              rr_ptr <= (call_q.counter == 3'(NUM_COUNTERS-1)) ? 3'd0 : call_q.counter + 3'd1;
            end
            state <= (|pending_next && !queue_empty) ? ARB : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
